// File: rtl/sa4_cache_ctrl.sv
// 4-way set-associative write-back/write-allocate cache controller with NRU replacement.
// Optional hit/miss counters when SA4_CACHE_STATS_EN is defined.
module sa4_cache_ctrl #(
  parameter int CACHE_LINES     = 256,
  parameter int WAYS            = 4,
  parameter int LINE_SIZE_BYTES = 64,
  parameter int TAG_BITS        = 18,
  parameter int INDEX_BITS      = 8,
  parameter int OFFSET_BITS     = 6,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int LINE_SIZE_BITS  = 8 * LINE_SIZE_BYTES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req,
  input  logic                      i_we,
  input  logic [ADDRESS_WIDTH-1:0]  i_addr,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  output logic                      o_busy,
  output logic                      o_valid,
  output logic [DATA_WIDTH-1:0]     o_rdata,
  output logic                      cache_miss,
  output logic                      o_mem_req,
  output logic [ADDRESS_WIDTH-1:0]  o_mem_addr,
  input  logic                      i_mem_resp,
  input  logic [LINE_SIZE_BITS-1:0] i_mem_line,
  output logic                      o_evict,
  output logic [ADDRESS_WIDTH-1:0]  o_evict_addr,
  output logic [LINE_SIZE_BITS-1:0] o_evict_data
`ifdef SA4_CACHE_STATS_EN
  ,
  output logic [31:0]               o_hit_cnt,
  output logic [31:0]               o_miss_cnt
`endif
);

  localparam int WORD_BITS = OFFSET_BITS - 2;
  localparam int WAY_BITS  = $clog2(WAYS);
  localparam int LB        = $clog2(LINE_SIZE_BITS);

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL} state_t;
  state_t state;

  logic [TAG_BITS-1:0]   tag_q;
  logic [INDEX_BITS-1:0] idx_q;
  logic [WORD_BITS-1:0]  word_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [LINE_SIZE_BITS-1:0] data_mem [WAYS][CACHE_LINES];
  logic [TAG_BITS-1:0]       tag_mem  [WAYS][CACHE_LINES];
  logic [WAYS-1:0]           valid_q  [CACHE_LINES];
  logic [WAYS-1:0]           dirty_q  [CACHE_LINES];
  logic [WAYS-1:0]           use_q    [CACHE_LINES];

  logic                      unused_addr_bits;
  assign unused_addr_bits = ^i_addr[1:0];

  logic [WAYS-1:0]           match;
  logic                      hit;
  logic [WAY_BITS-1:0]       hit_idx;
  logic [LINE_SIZE_BITS-1:0] hit_line, hit_merged, fill_line;
  logic [WAY_BITS-1:0]       victim;
  logic                      victim_found;
  logic [LB-1:0]             word_base;

  assign word_base = LB'(word_q) << $clog2(DATA_WIDTH);

  // Tag compare ANDed with valid per way, then a one-hot AND-OR mux of the lines.
  always_comb begin
    match    = '0;
    hit_line = '0;
    hit_idx  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      match[w] = valid_q[idx_q][w] && (tag_mem[w][idx_q] == tag_q);
      hit_line = hit_line | ({LINE_SIZE_BITS{match[w]}} & data_mem[w][idx_q]);
      if (match[w]) hit_idx = WAY_BITS'(w);
    end
    hit = |match;
    hit_merged = hit_line;
    if (we_q) hit_merged[word_base +: DATA_WIDTH] = wdata_q;
    fill_line = i_mem_line;
    if (we_q) fill_line[word_base +: DATA_WIDTH] = wdata_q;
  end

  // Victim: lowest invalid way first, otherwise lowest way whose use bit is clear.
  always_comb begin
    victim       = '0;
    victim_found = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!victim_found && !valid_q[idx_q][w]) begin
        victim       = WAY_BITS'(w);
        victim_found = 1'b1;
      end
    end
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!victim_found && !use_q[idx_q][w]) begin
        victim       = WAY_BITS'(w);
        victim_found = 1'b1;
      end
    end
  end

  function automatic logic [WAYS-1:0] nru_set(input logic [WAYS-1:0] u,
                                              input logic [WAY_BITS-1:0] w);
    logic [WAYS-1:0] oh;
    oh    = '0;
    oh[w] = 1'b1;
    nru_set = ((u | oh) == '1) ? oh : (u | oh);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      o_busy       <= 1'b0;
      o_valid      <= 1'b0;
      o_rdata      <= '0;
      cache_miss   <= 1'b0;
      o_mem_req    <= 1'b0;
      o_mem_addr   <= '0;
      o_evict      <= 1'b0;
      o_evict_addr <= '0;
      o_evict_data <= '0;
      tag_q        <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      for (int unsigned s = 0; s < CACHE_LINES; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        use_q[s]   <= '0;
      end
    end else begin
      o_valid <= 1'b0;
      o_evict <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req) begin
            tag_q   <= i_addr[ADDRESS_WIDTH-1 -: TAG_BITS];
            idx_q   <= i_addr[OFFSET_BITS +: INDEX_BITS];
            word_q  <= i_addr[2 +: WORD_BITS];
            we_q    <= i_we;
            wdata_q <= i_wdata;
            o_busy  <= 1'b1;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            o_rdata <= hit_merged[word_base +: DATA_WIDTH];
            if (we_q) dirty_q[idx_q][hit_idx] <= 1'b1;
            use_q[idx_q] <= nru_set(use_q[idx_q], hit_idx);
            o_valid <= 1'b1;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end else begin
            cache_miss <= 1'b1;
            o_mem_req  <= 1'b1;
            o_mem_addr <= {tag_q, idx_q, {OFFSET_BITS{1'b0}}};
            state      <= FILL;
          end
        end
        FILL: begin
          if (i_mem_resp) begin
            if (valid_q[idx_q][victim] && dirty_q[idx_q][victim]) begin
              o_evict      <= 1'b1;
              o_evict_addr <= {tag_mem[victim][idx_q], idx_q, {OFFSET_BITS{1'b0}}};
              o_evict_data <= data_mem[victim][idx_q];
            end
            valid_q[idx_q][victim] <= 1'b1;
            dirty_q[idx_q][victim] <= we_q;
            use_q[idx_q]           <= nru_set(use_q[idx_q], victim);
            o_rdata    <= fill_line[word_base +: DATA_WIDTH];
            o_valid    <= 1'b1;
            o_busy     <= 1'b0;
            cache_miss <= 1'b0;
            o_mem_req  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; their validity is tracked by valid_q.
  always_ff @(posedge clk) begin
    if (state == LOOKUP && hit && we_q) data_mem[hit_idx][idx_q] <= hit_merged;
    if (state == FILL && i_mem_resp) begin
      data_mem[victim][idx_q] <= fill_line;
      tag_mem[victim][idx_q]  <= tag_q;
    end
  end

`ifdef SA4_CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit) o_hit_cnt  <= o_hit_cnt + 32'd1;
      else     o_miss_cnt <= o_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sa4_cache_ctrl.sv
// Directed self-checking bench for sa4_cache_ctrl: misses, hits, NRU eviction, reset, busy handling.
module tb_sa4_cache_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         i_req, i_we, i_mem_resp;
  logic [31:0]  i_addr, i_wdata;
  logic [511:0] i_mem_line;
  logic         o_busy, o_valid, cache_miss, o_mem_req, o_evict;
  logic [31:0]  o_rdata, o_mem_addr, o_evict_addr;
  logic [511:0] o_evict_data;

  int tests = 0;
  int fails = 0;

  sa4_cache_ctrl dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_busy(o_busy), .o_valid(o_valid), .o_rdata(o_rdata), .cache_miss(cache_miss),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_resp(i_mem_resp),
    .i_mem_line(i_mem_line), .o_evict(o_evict), .o_evict_addr(o_evict_addr),
    .o_evict_data(o_evict_data)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] mk_line(input logic [31:0] w0, input logic [31:0] pat);
    logic [511:0] l;
    l = {16{pat}};
    l[31:0] = w0;
    return l;
  endfunction

  task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); i_req = 1'b1; i_we = we; i_addr = a; i_wdata = d;
    @(negedge clk); i_req = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (o_valid !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
  endtask

  task automatic serve_fill(input logic [511:0] line, output logic seen, output logic miss_seen,
                            output logic [31:0] maddr);
    int n;
    n = 0;
    while (o_mem_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    seen = (o_mem_req === 1'b1); miss_seen = (cache_miss === 1'b1); maddr = o_mem_addr;
    @(negedge clk);
    i_mem_resp = 1'b1; i_mem_line = line;
    @(negedge clk);
    i_mem_resp = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if ({o_busy, o_valid, cache_miss, o_mem_req, o_evict} !== 5'b0) begin fails++; $display("FAIL reset_flags got=%b exp=00000", {o_busy, o_valid, cache_miss, o_mem_req, o_evict}); end
    tests++; if (o_rdata !== 32'h0 || o_mem_addr !== 32'h0) begin fails++; $display("FAIL reset_data got rdata=%h maddr=%h exp=0", o_rdata, o_mem_addr); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy got=%b exp=0", o_busy); end
  endtask

  task automatic test_read_miss;
    logic s, m; logic [31:0] a;
    req(1'b0, 32'h0000_1000, 32'h0);
    serve_fill(mk_line(32'hDEAD_BEEF, 32'h1111_0000), s, m, a);
    tests++; if (s !== 1'b1 || m !== 1'b1) begin fails++; $display("FAIL miss_req got req=%b miss=%b exp=1 1", s, m); end
    tests++; if (a !== 32'h0000_1000) begin fails++; $display("FAIL miss_addr got=%h exp=00001000", a); end
    tests++; if (o_valid !== 1'b1 || o_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL miss_rdata got v=%b d=%h exp 1 deadbeef", o_valid, o_rdata); end
    tests++; if ({cache_miss, o_mem_req, o_evict, o_busy} !== 4'b0) begin fails++; $display("FAIL miss_done got=%b exp=0000", {cache_miss, o_mem_req, o_evict, o_busy}); end
    @(negedge clk);
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL miss_valid_pulse got=%b exp=0", o_valid); end
  endtask

  task automatic test_read_hit;
    int c;
    req(1'b0, 32'h0000_1000, 32'h0);
    tests++; if (o_busy !== 1'b1 || o_valid !== 1'b0 || cache_miss !== 1'b0) begin fails++; $display("FAIL hit_inflight got busy=%b v=%b miss=%b exp 1 0 0", o_busy, o_valid, cache_miss); end
    wait_valid(c);
    tests++; if (c !== 2) begin fails++; $display("FAIL hit_latency got=%0d exp=2", c); end
    tests++; if (o_rdata !== 32'hDEAD_BEEF || o_mem_req !== 1'b0) begin fails++; $display("FAIL hit_rdata got=%h req=%b exp deadbeef 0", o_rdata, o_mem_req); end
  endtask

  task automatic test_write_hit;
    int c;
    req(1'b1, 32'h0000_1004, 32'h1234_5678);
    wait_valid(c);
    tests++; if (c !== 2 || o_rdata !== 32'h1234_5678) begin fails++; $display("FAIL wr_hit got cyc=%0d d=%h exp 2 12345678", c, o_rdata); end
    tests++; if (o_mem_req !== 1'b0 || cache_miss !== 1'b0) begin fails++; $display("FAIL wr_hit_nomem got req=%b miss=%b exp 0 0", o_mem_req, cache_miss); end
    req(1'b0, 32'h0000_1004, 32'h0);
    wait_valid(c);
    tests++; if (c !== 2 || o_rdata !== 32'h1234_5678) begin fails++; $display("FAIL wr_readback got cyc=%0d d=%h exp 2 12345678", c, o_rdata); end
    req(1'b0, 32'h0000_1000, 32'h0);
    wait_valid(c);
    tests++; if (o_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_neighbor got=%h exp=deadbeef", o_rdata); end
  endtask

  task automatic test_eviction;
    logic s, m; logic [31:0] a, ad;
    for (int k = 1; k <= 4; k++) begin
      ad = (32'(k) << 14) | 32'h0000_1000;
      req(1'b0, ad, 32'h0);
      serve_fill(mk_line(32'hA000_0000 + 32'(k), 32'h2222_0000), s, m, a);
      tests++; if (s !== 1'b1 || a !== ad) begin fails++; $display("FAIL evict_fill%0d got req=%b addr=%h exp 1 %h", k, s, a, ad); end
      tests++; if (o_evict !== (k == 4) || o_rdata !== 32'hA000_0000 + 32'(k)) begin fails++; $display("FAIL evict_pulse%0d got ev=%b d=%h exp %b %h", k, o_evict, o_rdata, (k == 4), 32'hA000_0000 + 32'(k)); end
    end
    tests++; if (o_evict_addr !== 32'h0000_1000) begin fails++; $display("FAIL evict_addr got=%h exp=00001000", o_evict_addr); end
    tests++; if (o_evict_data[95:0] !== {32'h1111_0000, 32'h1234_5678, 32'hDEAD_BEEF}) begin fails++; $display("FAIL evict_data got=%h exp=11110000_12345678_deadbeef", o_evict_data[95:0]); end
    @(negedge clk);
    tests++; if (o_evict !== 1'b0 || o_evict_addr !== 32'h0000_1000) begin fails++; $display("FAIL evict_hold got ev=%b a=%h exp 0 00001000", o_evict, o_evict_addr); end
  endtask

  task automatic test_write_miss;
    logic s, m; logic [31:0] a; int c;
    req(1'b1, 32'h0001_5008, 32'hCAFE_F00D);
    serve_fill(mk_line(32'h0BAD_0000, 32'h3333_0000), s, m, a);
    tests++; if (a !== 32'h0001_5000 || o_evict !== 1'b0 || o_rdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL wmiss got a=%h ev=%b d=%h exp 00015000 0 cafef00d", a, o_evict, o_rdata); end
    req(1'b0, 32'h0001_5008, 32'h0);
    wait_valid(c);
    tests++; if (c !== 2 || o_rdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL wmiss_merge got cyc=%0d d=%h exp 2 cafef00d", c, o_rdata); end
    req(1'b0, 32'h0001_5000, 32'h0);
    wait_valid(c);
    tests++; if (o_rdata !== 32'h0BAD_0000) begin fails++; $display("FAIL wmiss_word0 got=%h exp=0bad0000", o_rdata); end
  endtask

  task automatic test_reset_mid_miss;
    logic s, m; logic [31:0] a; int n;
    req(1'b0, 32'h0000_2000, 32'h0);
    n = 0;
    while (o_mem_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    tests++; if (o_mem_req !== 1'b1) begin fails++; $display("FAIL rstmid_req got=%b exp=1", o_mem_req); end
    rst = 1'b1; #1;
    tests++; if ({o_busy, o_valid, cache_miss, o_mem_req, o_evict} !== 5'b0 || o_mem_addr !== 32'h0 || o_rdata !== 32'h0) begin fails++; $display("FAIL rstmid_out got flags=%b maddr=%h d=%h exp 0", {o_busy, o_valid, cache_miss, o_mem_req, o_evict}, o_mem_addr, o_rdata); end
    tests++; if (o_evict_addr !== 32'h0 || o_evict_data !== 512'h0) begin fails++; $display("FAIL rstmid_evict got a=%h exp 0", o_evict_addr); end
    @(negedge clk); rst = 1'b0;
    req(1'b0, 32'h0001_5008, 32'h0);
    serve_fill(mk_line(32'h0, 32'h4444_0000), s, m, a);
    tests++; if (s !== 1'b1 || m !== 1'b1 || a !== 32'h0001_5000) begin fails++; $display("FAIL rstmid_remiss got req=%b miss=%b a=%h exp 1 1 00015000", s, m, a); end
    tests++; if (o_rdata !== 32'h4444_0000) begin fails++; $display("FAIL rstmid_rdata got=%h exp=44440000", o_rdata); end
  endtask

  task automatic test_busy_ignore;
    logic s, m; logic [31:0] a; int vc;
    req(1'b0, 32'h0000_1000, 32'h0);
    i_req = 1'b1; i_we = 1'b1; i_addr = 32'h0000_3000; i_wdata = 32'h5555_5555;
    @(negedge clk); @(negedge clk);
    i_req = 1'b0;
    serve_fill(mk_line(32'h7777_0001, 32'h6666_0000), s, m, a);
    tests++; if (a !== 32'h0000_1000 || o_rdata !== 32'h7777_0001) begin fails++; $display("FAIL busy_addr got a=%h d=%h exp 00001000 77770001", a, o_rdata); end
    vc = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_valid === 1'b1) vc++;
      if (i == 2) i_mem_resp = 1'b1;
      if (i == 3) i_mem_resp = 1'b0;
      @(negedge clk);
    end
    tests++; if (vc !== 1 || o_busy !== 1'b0) begin fails++; $display("FAIL busy_single_valid got cnt=%0d busy=%b exp 1 0", vc, o_busy); end
    req(1'b0, 32'h0000_3000, 32'h0);
    serve_fill(mk_line(32'h8888_0000, 32'h0), s, m, a);
    tests++; if (s !== 1'b1 || a !== 32'h0000_3000 || o_rdata !== 32'h8888_0000) begin fails++; $display("FAIL busy_ignored_wr got req=%b a=%h d=%h exp 1 00003000 88880000", s, a, o_rdata); end
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
    i_mem_resp = 1'b0; i_mem_line = '0;
    test_reset;
    test_read_miss;
    test_read_hit;
    test_write_hit;
    test_eviction;
    test_write_miss;
    test_reset_mid_miss;
    test_busy_ignore;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
